div_issue_ctrl: RTL and testbench

Issue/collect controller placed directly upstream of the team's multi-cycle serial divider (clk, reset-pulse start, A/B in, mod/div/done out).
- Accepts operand pairs over a valid/ready handshake.
- Launches the divider with a one-cycle start pulse, holds operands stable, and waits for done.
- Captures quotient/remainder and presents them over a valid/ready result handshake.
- Adds a timeout watchdog and error reporting, so software-side and bench sequencing no longer hand-toggle reset.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_watchdog.sv | 31 +++
 rtl/div_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the divider issue/collect controller.
package div_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/div_watchdog.sv
// Clearable saturating cycle counter. o_expired is high once the count has
// reached TIMEOUT-1; the count then holds there instead of wrapping.
module div_watchdog
  import div_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // count enabled cycles, clear on request, stop at the limit
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/collect controller sitting in front of the serial divider.
// Optional build macro: DIV_ZERO_BYPASS_EN -- when defined, a zero divisor
// is answered locally (quot all ones, mod = dividend, DIV0) without starting
// the divider.
//
// state  | meaning
// IDLE   | ready for an operand pair
// LAUNCH | one-cycle start pulse to the divider
// SETTLE | let a stale done from the previous op clear; arm the watchdog
// WAIT   | wait for done or watchdog expiry
// HOLD   | result presented until out_ready
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_mod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_mod,
  output logic [1:0]       out_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_mod;
  err_t             r_err;

  logic w_accept;
  logic w_bypass;
  logic w_cap_done;
  logic w_cap_to;
  logic w_wd_clear;
  logic w_wd_en;
  logic w_wd_expired;
  err_t w_done_err;

  div_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  // next-state decode and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bypass    = 1'b0;
    w_cap_done  = 1'b0;
    w_cap_to    = 1'b0;
    w_wd_clear  = 1'b0;
    w_wd_en     = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    w_done_err  = ERR_OK;
`else
    // zero divisor still runs through the divider but is flagged on done
    w_done_err  = (r_div_b == '0) ? ERR_DIV0 : ERR_OK;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
          w_bypass = (in_b == '0);
`endif
          w_state_nxt = w_bypass ? HOLD : LAUNCH;
        end
      end
      LAUNCH: w_state_nxt = SETTLE;
      SETTLE: begin
        w_wd_clear  = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_wd_en = 1'b1;
        if (div_done) begin
          w_cap_done  = 1'b1;
          w_state_nxt = HOLD;
        end else if (w_wd_expired) begin
          w_cap_to    = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // operand latch and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_a <= '0;
      r_div_b <= '0;
      r_quot  <= '0;
      r_mod   <= '0;
      r_err   <= ERR_OK;
    end else begin
      if (w_accept) begin
        r_div_a <= in_a;
        r_div_b <= in_b;
      end
      if (w_bypass) begin
        r_quot <= '1;
        r_mod  <= in_a;
        r_err  <= ERR_DIV0;
      end else if (w_cap_done) begin
        r_quot <= div_quot;
        r_mod  <= div_mod;
        r_err  <= w_done_err;
      end else if (w_cap_to) begin
        r_quot <= '0;
        r_mod  <= '0;
        r_err  <= ERR_TIMEOUT;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign div_start = (r_state == LAUNCH);
  assign out_valid = (r_state == HOLD);
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign out_quot  = r_quot;
  assign out_mod   = r_mod;
  assign out_err   = r_err;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural divider of programmable latency.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int W  = 8;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         div_start;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_done;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_mod;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_mod;
  logic [1:0]   out_err;

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_done  (div_done),
    .div_quot  (div_quot),
    .div_mod   (div_mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_mod   (out_mod),
    .out_err   (out_err)
  );

  // divider model: mode 0 normal, 1 done stuck low, 2 done stuck high.
  // done rises m_lat cycles after the start cycle and stays high until the
  // next start, like a real divider's sticky done flag.
  int           m_mode = 0;
  int           m_lat  = 9;
  int           m_cnt  = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_m = '0;

  always @(posedge clk) begin
    if (div_start) begin
      if (div_b == '0) begin
        m_q <= '1;
        m_m <= div_a;
      end else begin
        m_q <= div_a / div_b;
        m_m <= div_a % div_b;
      end
      m_cnt  <= m_lat - 1;
      m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end

  assign div_done = (m_mode == 1) ? 1'b0 : (m_mode == 2) ? 1'b1 : m_done;
  assign div_quot = m_q;
  assign div_mod  = m_m;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    int         mode;
    int         lat;
    int         hold;
    int         q;
    int         m;
    int         err;
    int         n;
    int         starts;
  } vec_t;

  function automatic vec_t mk(string nm, int a, int b, int mode, int lat, int hold,
                              int q, int m, int err, int n, int starts);
    vec_t v;
    v.name = nm; v.a = 8'(a); v.b = 8'(b); v.mode = mode; v.lat = lat; v.hold = hold;
    v.q = q; v.m = m; v.err = err; v.n = n; v.starts = starts;
    return v;
  endfunction

  // one operation: offer, follow to out_valid, optionally stall, handshake
  task automatic do_op(input vec_t v);
    int n;
    int starts;
    bit busy_ok;
    bit stable_ok;
    m_mode    = v.mode;
    m_lat     = v.lat;
    in_a      = v.a;
    in_b      = v.b;
    in_valid  = 1'b1;
    out_ready = (v.hold == 0);
    chk({v.name, " in_ready idle"}, int'(in_ready), 1);
    @(posedge clk);
    n = 0; starts = 0; busy_ok = 1'b1; stable_ok = 1'b1;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
      if (div_start) starts++;
      if (in_ready) busy_ok = 1'b0;
      if (div_a != v.a || div_b != v.b) stable_ok = 1'b0;
    end while (!out_valid && n < 300);
    chk({v.name, " latency"}, n, v.n);
    chk({v.name, " start pulses"}, starts, v.starts);
    chk({v.name, " in_ready low while busy"}, int'(busy_ok), 1);
    chk({v.name, " operands stable"}, int'(stable_ok), 1);
    chk({v.name, " quot"}, int'(out_quot), v.q);
    chk({v.name, " mod"}, int'(out_mod), v.m);
    chk({v.name, " err"}, int'(out_err), v.err);
    if (v.hold > 0) begin
      in_a = ~v.a;
      in_b = 8'd3;
      in_valid = 1'b1;
      repeat (v.hold) @(negedge clk);
      chk({v.name, " held valid"}, int'(out_valid), 1);
      chk({v.name, " held quot"}, int'(out_quot), v.q);
      chk({v.name, " held mod"}, int'(out_mod), v.m);
      chk({v.name, " in_ready during hold"}, int'(in_ready), 0);
      chk({v.name, " offer ignored"}, int'(div_a), int'(v.a));
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({v.name, " valid drops"}, int'(out_valid), 0);
    chk({v.name, " back to idle"}, int'(in_ready), 1);
    chk({v.name, " quot kept"}, int'(out_quot), v.q);
    out_ready = 1'b0;
  endtask

  vec_t vq[$];

  initial begin
    vq.push_back(mk("200/7", 200, 7, 0, 9, 0, 28, 4, 0, 11, 1));
    vq.push_back(mk("255/1", 255, 1, 0, 9, 0, 255, 0, 0, 11, 1));
    vq.push_back(mk("1/255", 1, 255, 0, 9, 0, 0, 1, 0, 11, 1));
    vq.push_back(mk("100/9 stall", 100, 9, 0, 9, 5, 11, 1, 0, 11, 1));
    vq.push_back(mk("50/5 timeout", 50, 5, 1, 9, 0, 0, 0, 2, TO + 3, 1));
    vq.push_back(mk("84/4 stale done", 84, 4, 2, 9, 0, 21, 0, 0, 4, 1));
    vq.push_back(mk("done on last wait", 150, 10, 0, TO + 1, 0, 15, 0, 0, TO + 3, 1));
    vq.push_back(mk("done after limit", 150, 10, 0, TO + 2, 0, 0, 0, 2, TO + 3, 1));
    vq.push_back(mk("13/13 lat2", 13, 13, 0, 2, 0, 1, 0, 0, 4, 1));
    vq.push_back(mk("0/5", 0, 5, 0, 9, 0, 0, 0, 0, 11, 1));
`ifdef DIV_ZERO_BYPASS_EN
    vq.push_back(mk("37/0 bypass", 37, 0, 0, 9, 0, 255, 37, 1, 1, 0));
    vq.push_back(mk("37/0 bypass dead div", 37, 0, 1, 9, 0, 255, 37, 1, 1, 0));
`else
    vq.push_back(mk("37/0 launch", 37, 0, 0, 9, 0, 255, 37, 1, 11, 1));
    vq.push_back(mk("37/0 no done", 37, 0, 1, 9, 0, 0, 0, 2, TO + 3, 1));
`endif

    repeat (2) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset div_start", int'(div_start), 0);
    chk("reset out_err", int'(out_err), 0);
    chk("reset out_quot", int'(out_quot), 0);
    chk("reset div_a", int'(div_a), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      do_op(vq[i]);
    end

    // reset while in WAIT discards the in-flight operation
    begin
      bit quiet;
      m_mode = 0; m_lat = 9;
      in_a = 8'd90; in_b = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre-reset busy", int'(in_ready), 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid reset in_ready", int'(in_ready), 1);
      chk("mid reset out_valid", int'(out_valid), 0);
      chk("mid reset out_quot", int'(out_quot), 0);
      chk("mid reset out_mod", int'(out_mod), 0);
      chk("mid reset out_err", int'(out_err), 0);
      chk("mid reset div_a", int'(div_a), 0);
      chk("mid reset div_b", int'(div_b), 0);
      quiet = 1'b1;
      repeat (15) begin
        @(negedge clk);
        if (out_valid || div_start) quiet = 1'b0;
      end
      chk("abandoned result discarded", int'(quiet), 1);
      out_ready = 1'b0;
      do_op(mk("20/3 after reset", 20, 3, 0, 9, 0, 6, 2, 0, 11, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global time limit: got timeout expected completion");
    $fatal(1);
  end

endmodule
